ntt_bfly_pe: RTL and testbench
==============================

NTT_BFLY_PE -- requirements
Module: ntt_bfly_pe

Interface
REQ-001 Parameter W, default 28, data/twiddle width in bits.
REQ-002 Parameter Q, default 268369921 (2^28-2^16+1), modulus; Q < 2^W.
REQ-003 Parameter NTW, default 16, twiddle table depth; power of two, >= 2.
REQ-004 Parameter MUL_LAT, default 6, modular multiplier pipeline depth in cycles, >= 1.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  input beat present this cycle.
REQ-008 in_mode  input  1  0 = Cooley-Tukey (forward), 1 = Gentleman-Sande (inverse); sampled with in_valid.
REQ-009 frame_start  input  1  restarts twiddle sequencing at index 0.
REQ-010 x_in  input  W  upper operand, < Q.
REQ-011 y_in  input  W  lower operand, < Q.
REQ-012 tw_we  input  1  twiddle table write enable.
REQ-013 tw_addr  input  log2(NTW)  twiddle write address.
REQ-014 tw_data  input  W  twiddle write value, < Q.
REQ-015 out_valid  output  1  output beat present.
REQ-016 x_out  output  W  upper result, < Q.
REQ-017 y_out  output  W  lower result, < Q.

Function
REQ-018 Mode 0: x_out = (x + w*y) mod Q, y_out = (x - w*y) mod Q.
REQ-019 Mode 1: x_out = (x + y) mod Q, y_out = ((x - y) mod Q) * w mod Q.
REQ-020 Fixed latency L = MUL_LAT + 2 cycles for both modes: a beat accepted at cycle t appears with out_valid high at cycle t+L.
REQ-021 No backpressure; one beat per cycle accepted; back-to-back beats produce back-to-back outputs.
REQ-022 Mode travels with its beat; beats of different modes may be interleaved, each computed in its own mode.
REQ-023 Multiplier: full 2W-bit product reduced mod Q, MUL_LAT register stages; reduction method is implementation choice.
REQ-024 Add/sub: result in [0, Q-1]; subtraction adds Q on borrow; addition subtracts Q when sum >= Q.
REQ-025 Twiddle index idx (log2(NTW) bits): the beat uses w = table[idx]; idx increments after each accepted beat, wrapping NTW-1 -> 0.
REQ-026 frame_start without in_valid: idx <= 0.
REQ-027 frame_start with in_valid: the beat uses table[0]; idx <= 1.
REQ-028 Table write at cycle t is visible to beats accepted at t+1 or later; a same-cycle read returns the old value.
REQ-029 When out_valid is low, x_out/y_out hold their last values.
REQ-030 Operands >= Q: outputs undefined; out_valid timing unaffected.

Reset
REQ-031 rst clears all pipeline valids, idx <= 0, out_valid <= 0, x_out <= 0, y_out <= 0.
REQ-032 rst has priority over in_valid, frame_start and tw_we; beats in flight are discarded; no out_valid for 1..L cycles after rst.
REQ-033 Twiddle table contents are not cleared by rst.

Verification
REQ-034 Defaults, table[0]=2, mode 0, x=5, y=3 -> after 8 cycles x_out=11, y_out=268369920.
REQ-035 Same operands, mode 1 -> x_out=8, y_out=4; then interleave modes 0/1/0 back-to-back -> outputs 11/8/11, each with matching y_out.
REQ-036 Wrap: table[0]=1, mode 0, x=Q-1, y=1 -> x_out=0, y_out=Q-2.
REQ-037 NTW=4, table={1,2,3,4}, frame_start with first beat, mode 0, x=0, y=1, five beats -> x_out sequence 1,2,3,4,1; frame_start on beat 3 -> 1,2,1,2,3.
REQ-038 Three beats in flight, rst pulsed one cycle -> out_valid stays 0 for the next L cycles; table contents unchanged; next beat after rst uses table[0].

Source files
------------

// File: rtl/ntt_bfly_pe_if.sv
// ntt_bfly_pe_if -- beat, twiddle-write and result signals of the NTT butterfly PE.
//   master : drives in_valid/in_mode/frame_start/x_in/y_in and tw_we/tw_addr/tw_data,
//            receives out_valid/x_out/y_out
//   slave  : the PE side of the same signals
interface ntt_bfly_pe_if #(
    parameter int W   = 28,
    parameter int NTW = 16
);
    localparam int AW = $clog2(NTW);

    logic          in_valid;
    logic          in_mode;
    logic          frame_start;
    logic [W-1:0]  x_in;
    logic [W-1:0]  y_in;
    logic          tw_we;
    logic [AW-1:0] tw_addr;
    logic [W-1:0]  tw_data;
    logic          out_valid;
    logic [W-1:0]  x_out;
    logic [W-1:0]  y_out;

    modport master (
        output in_valid, in_mode, frame_start, x_in, y_in, tw_we, tw_addr, tw_data,
        input  out_valid, x_out, y_out
    );

    modport slave (
        input  in_valid, in_mode, frame_start, x_in, y_in, tw_we, tw_addr, tw_data,
        output out_valid, x_out, y_out
    );
endinterface

// File: rtl/ntt_bfly_pe.sv
// ntt_bfly_pe -- pipelined radix-2 NTT butterfly with an internal twiddle table.
//   mode 0 (CT): x' = x + w*y, y' = x - w*y       (mod Q)
//   mode 1 (GS): x' = x + y,   y' = (x - y) * w   (mod Q)
// Fixed latency MUL_LAT+2 for both modes: one input register, MUL_LAT multiplier
// stages, one add/sub + output register.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (pipeline valids, twiddle index, outputs)
//   bus  - ntt_bfly_pe_if.slave: beats in, twiddle table writes, results out
module ntt_bfly_pe #(
    parameter int     W       = 28,
    parameter longint Q       = 268369921,
    parameter int     NTW     = 16,
    parameter int     MUL_LAT = 6
) (
    input  logic          clk,
    input  logic          rst,
    ntt_bfly_pe_if.slave  bus
);
    localparam int              AW = $clog2(NTW);
    localparam int              LS = MUL_LAT - 1;
    localparam logic [W:0]      QE = (W+1)'(Q);
    localparam logic [2*W-1:0]  Q2 = (2*W)'(Q);

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= QE) s = s - QE;
        return s[W-1:0];
    endfunction

    // Operands are < Q < 2^W, so bit W of the (W+1)-bit difference is the borrow.
    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W]) d = d + QE;
        return d[W-1:0];
    endfunction

    logic [W-1:0]  tw_mem [NTW];
    logic [AW-1:0] idx;
    logic [AW-1:0] rd_idx;

    logic          s0_v;
    logic          s0_mode;
    logic [W-1:0]  s0_x;
    logic [W-1:0]  s0_y;
    logic [W-1:0]  s0_w;

    logic [MUL_LAT-1:0] mul_v;
    logic [MUL_LAT-1:0] mul_mode;
    logic [W-1:0]       mul_m [MUL_LAT];
    // Operand carried alongside the product: x in mode 0, (x+y) mod Q in mode 1.
    logic [W-1:0]       mul_c [MUL_LAT];

    logic [W-1:0]   add_xy;
    logic [W-1:0]   sub_xy;
    logic [W-1:0]   mul_a;
    logic [2*W-1:0] prod;
    logic [W-1:0]   fin_x;
    logic [W-1:0]   fin_y;

    // Table write is non-blocking, so a same-cycle read sees the old entry.
    always_ff @(posedge clk) begin
        if (!rst && bus.tw_we) tw_mem[bus.tw_addr] <= bus.tw_data;
    end

    assign rd_idx = bus.frame_start ? '0 : idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_v <= 1'b0;
            idx  <= '0;
        end else begin
            s0_v <= bus.in_valid;
            if (bus.in_valid)
                idx <= bus.frame_start ? AW'(1) : idx + AW'(1);
            else if (bus.frame_start)
                idx <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            s0_mode <= bus.in_mode;
            s0_x    <= bus.x_in;
            s0_y    <= bus.y_in;
            s0_w    <= tw_mem[rd_idx];
        end
    end

    // GS does its add/sub ahead of the multiplier; CT multiplies y directly.
    assign add_xy = mod_add(s0_x, s0_y);
    assign sub_xy = mod_sub(s0_x, s0_y);
    assign mul_a  = s0_mode ? sub_xy : s0_y;
    assign prod   = {{W{1'b0}}, mul_a} * {{W{1'b0}}, s0_w};

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_v <= '0;
        end else begin
            mul_v[0] <= s0_v;
            for (int i = 1; i < MUL_LAT; i++) mul_v[i] <= mul_v[i-1];
        end
    end

    // Reduction happens in the first stage; the remaining stages give the tool
    // room to retime the multiply/reduce logic.
    always_ff @(posedge clk) begin
        mul_m[0]    <= W'(prod % Q2);
        mul_c[0]    <= s0_mode ? add_xy : s0_x;
        mul_mode[0] <= s0_mode;
        for (int i = 1; i < MUL_LAT; i++) begin
            mul_m[i]    <= mul_m[i-1];
            mul_c[i]    <= mul_c[i-1];
            mul_mode[i] <= mul_mode[i-1];
        end
    end

    always_comb begin
        fin_x = mod_add(mul_c[LS], mul_m[LS]);
        fin_y = mod_sub(mul_c[LS], mul_m[LS]);
        if (mul_mode[LS]) begin
            fin_x = mul_c[LS];
            fin_y = mul_m[LS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.x_out     <= '0;
            bus.y_out     <= '0;
        end else begin
            bus.out_valid <= mul_v[LS];
            if (mul_v[LS]) begin
                bus.x_out <= fin_x;
                bus.y_out <= fin_y;
            end
        end
    end
endmodule

// File: tb/tb_ntt_bfly_pe.sv
// tb_ntt_bfly_pe -- directed and randomized checks of ntt_bfly_pe against a
// delay-line reference model computing butterflies with plain modular arithmetic.
module tb_ntt_bfly_pe;
    localparam int     W       = 28;
    localparam longint Q       = 268369921;
    localparam int     NTW     = 4;
    localparam int     MUL_LAT = 6;
    localparam int     L       = MUL_LAT + 2;

    logic clk;
    logic rst;

    ntt_bfly_pe_if #(.W(W), .NTW(NTW)) bus ();

    ntt_bfly_pe #(.W(W), .Q(Q), .NTW(NTW), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit     v;
        longint x;
        longint y;
    } exp_t;

    exp_t         pipe [$];
    longint       m_tab [NTW];
    int           m_idx = 0;
    logic         m_ov = 1'b0;
    logic [W-1:0] m_x = '0;
    logic [W-1:0] m_y = '0;

    bit     b_mode [8];
    longint b_x    [8];
    longint b_y    [8];
    bit     b_fs   [8];
    bit     b_twe  [8];
    int     b_twa  [8];
    longint b_twd  [8];

    int     cap_n;
    longint cap_x [16];
    longint cap_y [16];
    int     cap_t [16];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void bfly(input bit mode, input longint x, input longint y,
                                 input longint w, output longint xo, output longint yo);
        longint m;
        if (!mode) begin
            m  = (w * y) % Q;
            xo = (x + m) % Q;
            yo = (x - m + Q) % Q;
        end else begin
            xo = (x + y) % Q;
            yo = (((x - y + Q) % Q) * w) % Q;
        end
    endfunction

    // One clock: the model consumes the inputs sampled at this edge.
    task automatic tick();
        exp_t e;
        int   k;
        longint ex, ey;
        e.v = 1'b0; e.x = 0; e.y = 0;
        @(posedge clk);
        if (rst) begin
            pipe.delete();
            for (int i = 0; i < L - 1; i++) pipe.push_back(e);
            m_ov = 1'b0; m_x = '0; m_y = '0; m_idx = 0;
        end else begin
            if (bus.in_valid) begin
                k = bus.frame_start ? 0 : m_idx;
                bfly(bus.in_mode, longint'(bus.x_in), longint'(bus.y_in), m_tab[k], ex, ey);
                e.v = 1'b1; e.x = ex; e.y = ey;
                m_idx = (k + 1) % NTW;
            end else if (bus.frame_start) begin
                m_idx = 0;
            end
            if (bus.tw_we) m_tab[bus.tw_addr] = longint'(bus.tw_data);
            pipe.push_back(e);
            if (pipe.size() >= L) begin
                e = pipe.pop_front();
                m_ov = e.v;
                if (e.v) begin
                    m_x = W'(e.x);
                    m_y = W'(e.y);
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        bus.in_valid    = 1'b0;
        bus.in_mode     = 1'b0;
        bus.frame_start = 1'b0;
        bus.x_in        = '0;
        bus.y_in        = '0;
        bus.tw_we       = 1'b0;
        bus.tw_addr     = '0;
        bus.tw_data     = '0;
    endtask

    task automatic tw_write(input int addr, input longint data);
        idle();
        bus.tw_we   = 1'b1;
        bus.tw_addr = 2'(addr);
        bus.tw_data = W'(data);
        tick();
        idle();
    endtask

    task automatic clr_seq();
        for (int i = 0; i < 8; i++) begin
            b_mode[i] = 0; b_x[i] = 0; b_y[i] = 0; b_fs[i] = 0;
            b_twe[i] = 0; b_twa[i] = 0; b_twd[i] = 0;
        end
    endtask

    // Drives n back-to-back beats, then idles L cycles, capturing every output beat
    // and the tick (1 = first beat's sampling edge) on which it appeared.
    task automatic run_seq(input int n);
        cap_n = 0;
        for (int i = 0; i < 16; i++) begin cap_x[i] = -1; cap_y[i] = -1; cap_t[i] = 0; end
        for (int t = 1; t <= n + L; t++) begin
            idle();
            if (t <= n) begin
                bus.in_valid    = 1'b1;
                bus.in_mode     = b_mode[t-1];
                bus.x_in        = W'(b_x[t-1]);
                bus.y_in        = W'(b_y[t-1]);
                bus.frame_start = b_fs[t-1];
                bus.tw_we       = b_twe[t-1];
                bus.tw_addr     = 2'(b_twa[t-1]);
                bus.tw_data     = W'(b_twd[t-1]);
            end
            tick();
            if (bus.out_valid === 1'b1 && cap_n < 16) begin
                cap_x[cap_n] = longint'(bus.x_out);
                cap_y[cap_n] = longint'(bus.y_out);
                cap_t[cap_n] = t;
                cap_n++;
            end
        end
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.x_out !== '0 || bus.y_out !== '0) begin
            errors++; $display("FAIL reset_outputs got x=%0d y=%0d want 0 0", bus.x_out, bus.y_out);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_basic();
        tw_write(0, 2);
        clr_seq();
        b_x[0] = 5; b_y[0] = 3; b_fs[0] = 1;
        run_seq(1);
        checks++;
        if (cap_n != 1 || cap_t[0] != L) begin
            errors++; $display("FAIL basic_latency got n=%0d t=%0d want n=1 t=%0d", cap_n, cap_t[0], L);
        end
        checks++;
        if (cap_x[0] != 11 || cap_y[0] != 268369920) begin
            errors++; $display("FAIL basic_ct got x=%0d y=%0d want 11 268369920", cap_x[0], cap_y[0]);
        end
    endtask

    task automatic test_mode1();
        for (int i = 1; i < NTW; i++) tw_write(i, 2);
        clr_seq();
        b_mode[0] = 1; b_x[0] = 5; b_y[0] = 3; b_fs[0] = 1;
        run_seq(1);
        checks++;
        if (cap_n != 1 || cap_t[0] != L || cap_x[0] != 8 || cap_y[0] != 4) begin
            errors++; $display("FAIL gs_single got n=%0d t=%0d x=%0d y=%0d want 1 %0d 8 4",
                               cap_n, cap_t[0], cap_x[0], cap_y[0], L);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.x_out !== 28'd8 || bus.y_out !== 28'd4) begin
            errors++; $display("FAIL hold got v=%b x=%0d y=%0d want 0 8 4", bus.out_valid, bus.x_out, bus.y_out);
        end
        clr_seq();
        for (int i = 0; i < 3; i++) begin b_x[i] = 5; b_y[i] = 3; end
        b_mode[1] = 1; b_fs[0] = 1;
        run_seq(3);
        checks++;
        if (cap_n != 3 || cap_t[0] != L || cap_t[1] != L + 1 || cap_t[2] != L + 2) begin
            errors++; $display("FAIL interleave_timing got n=%0d t0=%0d t1=%0d t2=%0d want 3 %0d %0d %0d",
                               cap_n, cap_t[0], cap_t[1], cap_t[2], L, L + 1, L + 2);
        end
        checks++;
        if (cap_x[0] != 11 || cap_x[1] != 8 || cap_x[2] != 11 ||
            cap_y[0] != Q - 1 || cap_y[1] != 4 || cap_y[2] != Q - 1) begin
            errors++; $display("FAIL interleave_data got x=%0d/%0d/%0d y=%0d/%0d/%0d want 11/8/11 %0d/4/%0d",
                               cap_x[0], cap_x[1], cap_x[2], cap_y[0], cap_y[1], cap_y[2], Q - 1, Q - 1);
        end
    endtask

    task automatic test_wrap();
        tw_write(0, 1);
        clr_seq();
        b_x[0] = Q - 1; b_y[0] = 1; b_fs[0] = 1;
        b_mode[1] = 1; b_x[1] = Q - 1; b_y[1] = 2; b_fs[1] = 1;
        run_seq(2);
        checks++;
        if (cap_n != 2 || cap_x[0] != 0 || cap_y[0] != Q - 2) begin
            errors++; $display("FAIL wrap_ct got n=%0d x=%0d y=%0d want 2 0 %0d", cap_n, cap_x[0], cap_y[0], Q - 2);
        end
        checks++;
        if (cap_x[1] != 1 || cap_y[1] != Q - 3) begin
            errors++; $display("FAIL wrap_gs got x=%0d y=%0d want 1 %0d", cap_x[1], cap_y[1], Q - 3);
        end
    endtask

    task automatic test_twiddle_seq();
        for (int i = 0; i < NTW; i++) tw_write(i, i + 1);
        clr_seq();
        for (int i = 0; i < 5; i++) b_y[i] = 1;
        b_fs[0] = 1;
        run_seq(5);
        checks++;
        if (cap_n != 5 || cap_x[0] != 1 || cap_x[1] != 2 || cap_x[2] != 3 || cap_x[3] != 4 || cap_x[4] != 1) begin
            errors++; $display("FAIL tw_sequence got n=%0d x=%0d,%0d,%0d,%0d,%0d want 5 1,2,3,4,1",
                               cap_n, cap_x[0], cap_x[1], cap_x[2], cap_x[3], cap_x[4]);
        end
        checks++;
        if (cap_y[0] != Q - 1 || cap_y[3] != Q - 4) begin
            errors++; $display("FAIL tw_sequence_y got y0=%0d y3=%0d want %0d %0d", cap_y[0], cap_y[3], Q - 1, Q - 4);
        end
        b_fs[2] = 1;
        run_seq(5);
        checks++;
        if (cap_n != 5 || cap_x[0] != 1 || cap_x[1] != 2 || cap_x[2] != 1 || cap_x[3] != 2 || cap_x[4] != 3) begin
            errors++; $display("FAIL tw_restart got n=%0d x=%0d,%0d,%0d,%0d,%0d want 5 1,2,1,2,3",
                               cap_n, cap_x[0], cap_x[1], cap_x[2], cap_x[3], cap_x[4]);
        end
        clr_seq();
        b_y[0] = 1; b_fs[0] = 1;
        run_seq(1);
        idle();
        bus.frame_start = 1'b1;
        tick();
        idle();
        clr_seq();
        b_y[0] = 1;
        run_seq(1);
        checks++;
        if (cap_n != 1 || cap_x[0] != 1) begin
            errors++; $display("FAIL frame_idle got n=%0d x=%0d want 1 1", cap_n, cap_x[0]);
        end
    endtask

    task automatic test_tw_write();
        tw_write(0, 5);
        tw_write(1, 6);
        clr_seq();
        for (int i = 0; i < 4; i++) b_y[i] = 1;
        b_fs[0] = 1; b_twe[0] = 1; b_twa[0] = 0; b_twd[0] = 7;
        b_twe[1] = 1; b_twa[1] = 1; b_twd[1] = 9;
        b_fs[2] = 1;
        run_seq(4);
        checks++;
        if (cap_n != 4 || cap_x[0] != 5 || cap_x[1] != 6 || cap_x[2] != 7 || cap_x[3] != 9) begin
            errors++; $display("FAIL tw_write_timing got n=%0d x=%0d,%0d,%0d,%0d want 4 5,6,7,9",
                               cap_n, cap_x[0], cap_x[1], cap_x[2], cap_x[3]);
        end
    endtask

    task automatic test_reset_flight();
        int early;
        for (int i = 0; i < NTW; i++) tw_write(i, i + 1);
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.in_valid = 1'b1; bus.y_in = 28'd1; bus.frame_start = (i == 0);
            tick();
        end
        idle();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.y_in = 28'd1;
        bus.tw_we = 1'b1; bus.tw_addr = '0; bus.tw_data = 28'd99;
        tick();
        rst = 1'b0;
        idle();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.x_out !== '0 || bus.y_out !== '0) begin
            errors++; $display("FAIL flight_reset got v=%b x=%0d y=%0d want 0 0 0", bus.out_valid, bus.x_out, bus.y_out);
        end
        early = 0;
        for (int i = 1; i <= L; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL flight_discard got v=%b at cycle %0d after rst want 0", bus.out_valid, i);
            end
        end
        clr_seq();
        b_y[0] = 1;
        run_seq(1);
        checks++;
        if (cap_n != 1 || cap_t[0] != L || cap_x[0] != 1 || cap_y[0] != Q - 1) begin
            errors++; $display("FAIL flight_restart got n=%0d t=%0d x=%0d y=%0d want 1 %0d 1 %0d",
                               cap_n, cap_t[0], cap_x[0], cap_y[0], L, Q - 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < NTW; i++) tw_write(i, longint'($urandom_range(32'(Q - 1))));
        for (int c = 0; c < 600; c++) begin
            rst             = ($urandom_range(79) == 0);
            bus.in_valid    = ($urandom_range(3) != 0);
            bus.in_mode     = 1'($urandom_range(1));
            bus.frame_start = ($urandom_range(9) == 0);
            bus.x_in        = W'($urandom_range(32'(Q - 1)));
            bus.y_in        = W'($urandom_range(32'(Q - 1)));
            bus.tw_we       = ($urandom_range(7) == 0);
            bus.tw_addr     = 2'($urandom_range(NTW - 1));
            bus.tw_data     = W'($urandom_range(32'(Q - 1)));
            tick();
            checks++;
            if (bus.out_valid !== m_ov || bus.x_out !== m_x || bus.y_out !== m_y) begin
                errors++; $display("FAIL random cycle %0d got v=%b x=%0d y=%0d want v=%b x=%0d y=%0d",
                                   c, bus.out_valid, bus.x_out, bus.y_out, m_ov, m_x, m_y);
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_mode1();
        test_wrap();
        test_twiddle_seq();
        test_tw_write();
        test_reset_flight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
